// File: rtl/gfx256_render_arbiter.sv
// Round-robin arbiter sharing one gfx256 pixel renderer between NREQ pixel sources.
// The winning pixel is latched and held on the renderer inputs until ack or watchdog abort.
module gfx256_render_arbiter #(
   parameter int unsigned NREQ        = 4,
   parameter int unsigned point_width = 16,
   parameter int unsigned TIMEOUT     = 1024
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NREQ-1:0]               req_write_i,
   input  logic [NREQ*point_width-1:0]   req_x_i,
   input  logic [NREQ*point_width-1:0]   req_y_i,
   input  logic [NREQ*point_width-1:0]   req_z_i,
   input  logic [NREQ-1:0]               req_zen_i,
   input  logic [NREQ*32-1:0]            req_color_i,
   output logic [NREQ-1:0]               req_ack_o,
   output logic                          ren_write_o,
   output logic [point_width-1:0]        ren_x_o,
   output logic [point_width-1:0]        ren_y_o,
   output logic [point_width-1:0]        ren_z_o,
   output logic                          ren_zen_o,
   output logic [31:0]                   ren_color_o,
   input  logic                          ren_ack_i,
   output logic [$clog2(NREQ)-1:0]       grant_o,
   output logic                          busy_o,
   output logic                          err_o
);

   localparam int unsigned GW  = $clog2(NREQ);
   localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StAck} state_e;

   state_e                 state_q, state_d;
   logic [GW-1:0]          ptr_q, ptr_d;
   logic [GW-1:0]          grant_q, grant_d;
   logic [WdW-1:0]         wdog_q, wdog_d;
   logic                   err_q, err_d;
   logic [NREQ-1:0]        req_ack_q, req_ack_d;
   logic                   ren_write_q, ren_write_d;
   logic [point_width-1:0] ren_x_q, ren_x_d;
   logic [point_width-1:0] ren_y_q, ren_y_d;
   logic [point_width-1:0] ren_z_q, ren_z_d;
   logic                   ren_zen_q, ren_zen_d;
   logic [31:0]            ren_color_q, ren_color_d;

   logic [point_width-1:0] x_arr     [NREQ];
   logic [point_width-1:0] y_arr     [NREQ];
   logic [point_width-1:0] z_arr     [NREQ];
   logic [31:0]            color_arr [NREQ];

   for (genvar k = 0; k < NREQ; k++) begin : g_unpack
      assign x_arr[k]     = req_x_i[k*point_width +: point_width];
      assign y_arr[k]     = req_y_i[k*point_width +: point_width];
      assign z_arr[k]     = req_z_i[k*point_width +: point_width];
      assign color_arr[k] = req_color_i[k*32 +: 32];
   end

   // Search starts just past the last winner, so that source has the lowest priority.
   logic [GW-1:0] win;
   logic [GW-1:0] idx;
   logic          found;

   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         idx = GW'((32'(ptr_q) + i) % NREQ);
         if (!found && req_write_i[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      wdog_d      = wdog_q;
      err_d       = err_q;
      req_ack_d   = '0;
      ren_write_d = ren_write_q;
      ren_x_d     = ren_x_q;
      ren_y_d     = ren_y_q;
      ren_z_d     = ren_z_q;
      ren_zen_d   = ren_zen_q;
      ren_color_d = ren_color_q;

      unique case (state_q)
         StIdle: begin
            if (found) begin
               grant_d     = win;
               ptr_d       = win;
               ren_x_d     = x_arr[win];
               ren_y_d     = y_arr[win];
               ren_z_d     = z_arr[win];
               ren_zen_d   = req_zen_i[win];
               ren_color_d = color_arr[win];
               ren_write_d = 1'b1;
               wdog_d      = '0;
               state_d     = StIssue;
            end
         end
         StIssue: begin
            // A renderer ack wins over a watchdog expiry in the same cycle.
            if (ren_ack_i) begin
               ren_write_d        = 1'b0;
               req_ack_d[grant_q] = 1'b1;
               state_d            = StAck;
            end else if ((TIMEOUT != 0) && (wdog_q == WdLast)) begin
               ren_write_d        = 1'b0;
               err_d              = 1'b1;
               req_ack_d[grant_q] = 1'b1;
               state_d            = StAck;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         StAck: begin
            // Served source may still hold write this cycle; do not arbitrate.
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         ptr_q       <= GW'(NREQ - 1);
         grant_q     <= '0;
         wdog_q      <= '0;
         err_q       <= 1'b0;
         req_ack_q   <= '0;
         ren_write_q <= 1'b0;
         ren_x_q     <= '0;
         ren_y_q     <= '0;
         ren_z_q     <= '0;
         ren_zen_q   <= 1'b0;
         ren_color_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         wdog_q      <= wdog_d;
         err_q       <= err_d;
         req_ack_q   <= req_ack_d;
         ren_write_q <= ren_write_d;
         ren_x_q     <= ren_x_d;
         ren_y_q     <= ren_y_d;
         ren_z_q     <= ren_z_d;
         ren_zen_q   <= ren_zen_d;
         ren_color_q <= ren_color_d;
      end
   end

   assign req_ack_o   = req_ack_q;
   assign ren_write_o = ren_write_q;
   assign ren_x_o     = ren_x_q;
   assign ren_y_o     = ren_y_q;
   assign ren_z_o     = ren_z_q;
   assign ren_zen_o   = ren_zen_q;
   assign ren_color_o = ren_color_q;
   assign grant_o     = grant_q;
   assign busy_o      = (state_q != StIdle);
   assign err_o       = err_q;

endmodule

// File: tb/tb_gfx256_render_arbiter.sv
// Directed bench for gfx256_render_arbiter: arbitration order, ack routing, watchdog, reset.
module tb_gfx256_render_arbiter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req_write;
   logic [63:0]  req_x, req_y, req_z;
   logic [3:0]   req_zen;
   logic [127:0] req_color;
   logic [3:0]   req_ack;
   logic         ren_write;
   logic [15:0]  ren_x, ren_y, ren_z;
   logic         ren_zen;
   logic [31:0]  ren_color;
   logic         ren_ack;
   logic [1:0]   grant;
   logic         busy, err;

   int n_vec = 0;
   int n_err = 0;
   int cnt;
   int exp_g [5] = '{0, 1, 2, 3, 0};

   always #5 clk = ~clk;

   gfx256_render_arbiter #(
      .NREQ        (4),
      .point_width (16),
      .TIMEOUT     (16)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_write_i (req_write),
      .req_x_i     (req_x),
      .req_y_i     (req_y),
      .req_z_i     (req_z),
      .req_zen_i   (req_zen),
      .req_color_i (req_color),
      .req_ack_o   (req_ack),
      .ren_write_o (ren_write),
      .ren_x_o     (ren_x),
      .ren_y_o     (ren_y),
      .ren_z_o     (ren_z),
      .ren_zen_o   (ren_zen),
      .ren_color_o (ren_color),
      .ren_ack_i   (ren_ack),
      .grant_o     (grant),
      .busy_o      (busy),
      .err_o       (err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_src(input int k, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] z, input logic zen, input logic [31:0] color);
      req_x[k*16 +: 16]     = x;
      req_y[k*16 +: 16]     = y;
      req_z[k*16 +: 16]     = z;
      req_zen[k]            = zen;
      req_color[k*32 +: 32] = color;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst_n     = 1'b0;
      req_write = '0;
      req_x     = '0;
      req_y     = '0;
      req_z     = '0;
      req_zen   = '0;
      req_color = '0;
      ren_ack   = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_write", 64'(ren_write), 64'd0);
      chk("rst_ack",   64'(req_ack),   64'd0);
      chk("rst_busy",  64'(busy),      64'd0);
      chk("rst_err",   64'(err),       64'd0);
      chk("rst_grant", 64'(grant),     64'd0);
      chk("rst_x",     64'(ren_x),     64'd0);
      chk("rst_color", 64'(ren_color), 64'd0);

      rst_n = 1'b1;
      tick();

      // Stray renderer ack while idle
      ren_ack = 1'b1;
      tick();
      ren_ack = 1'b0;
      chk("idle_ack_req_ack", 64'(req_ack), 64'd0);
      chk("idle_ack_busy",    64'(busy),    64'd0);
      tick();
      chk("idle_ack_req_ack2", 64'(req_ack), 64'd0);

      // Single source 0, renderer acks in its 6th write cycle
      set_src(0, 16'd5, 16'd7, 16'd9, 1'b0, 32'hFF00FF00);
      req_write = 4'b0001;
      tick();
      chk("t1_write", 64'(ren_write), 64'd1);
      chk("t1_x",     64'(ren_x),     64'd5);
      chk("t1_y",     64'(ren_y),     64'd7);
      chk("t1_z",     64'(ren_z),     64'd9);
      chk("t1_zen",   64'(ren_zen),   64'd0);
      chk("t1_color", 64'(ren_color), 64'hFF00FF00);
      chk("t1_grant", 64'(grant),     64'd0);
      chk("t1_busy",  64'(busy),      64'd1);
      repeat (5) tick();
      chk("t1_write_held", 64'(ren_write), 64'd1);
      chk("t1_no_early_ack", 64'(req_ack), 64'd0);
      ren_ack = 1'b1;
      tick();
      ren_ack = 1'b0;
      chk("t1_req_ack",   64'(req_ack),   64'b0001);
      chk("t1_write_off", 64'(ren_write), 64'd0);
      req_write = 4'b0000;
      tick();
      chk("t1_ack_once", 64'(req_ack), 64'd0);
      chk("t1_idle",     64'(busy),    64'd0);
      chk("t1_x_holds",  64'(ren_x),   64'd5);

      // All four sources from reset: 0,1,2,3,0
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) set_src(k, 16'(16'h1000 + k), 16'(16'h2000 + k),
                                         16'(16'h3000 + k), 1'b1, 32'(32'hC0000000 + k));
      req_write = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         chk("t2_grant", 64'(grant), 64'(exp_g[k]));
         chk("t2_x",     64'(ren_x), 64'(16'h1000 + exp_g[k]));
         ren_ack = 1'b1;
         tick();
         ren_ack = 1'b0;
         chk("t2_req_ack", 64'(req_ack), 64'(4'b0001 << exp_g[k]));
         if (k < 4) begin
            tick();
            tick();
         end
      end
      req_write = 4'b0000;
      tick();

      // Source 2 streams; source 1 joins mid-burst and must be served before 2 repeats
      set_src(2, 16'h0200, 16'h0201, 16'h0202, 1'b0, 32'h22222222);
      set_src(1, 16'h0100, 16'h0101, 16'h0102, 1'b1, 32'h11111111);
      req_write = 4'b0100;
      tick();
      chk("t3_grant2", 64'(grant), 64'd2);
      chk("t3_x2",     64'(ren_x), 64'h0200);
      req_write = 4'b0110;
      tick();
      ren_ack = 1'b1;
      tick();
      ren_ack = 1'b0;
      chk("t3_ack2",       64'(req_ack),   64'b0100);
      chk("t3_ack_write0", 64'(ren_write), 64'd0);
      set_src(2, 16'h0222, 16'h0223, 16'h0224, 1'b0, 32'h22220000);
      tick();
      chk("t3_no_dup_ack", 64'(req_ack), 64'd0);
      chk("t3_idle_busy",  64'(busy),    64'd0);
      tick();
      chk("t3_grant1", 64'(grant),     64'd1);
      chk("t3_x1",     64'(ren_x),     64'h0100);
      chk("t3_zen1",   64'(ren_zen),   64'd1);
      ren_ack = 1'b1;
      tick();
      ren_ack = 1'b0;
      chk("t3_ack1", 64'(req_ack), 64'b0010);
      req_write = 4'b0100;
      tick();
      tick();
      chk("t3_grant2b", 64'(grant),     64'd2);
      chk("t3_x2b",     64'(ren_x),     64'h0222);
      chk("t3_color2b", 64'(ren_color), 64'h22220000);
      ren_ack = 1'b1;
      tick();
      ren_ack = 1'b0;
      chk("t3_ack2b", 64'(req_ack), 64'b0100);
      req_write = 4'b0000;
      tick();

      // Renderer never acks: abort after 16 write cycles
      req_write = 4'b1000;
      tick();
      chk("t4_grant3",  64'(grant), 64'd3);
      chk("t4_err_pre", 64'(err),   64'd0);
      cnt = 0;
      while (ren_write === 1'b1 && cnt < 40) begin
         cnt++;
         tick();
      end
      chk("t4_write_cycles", 64'(cnt),       64'd16);
      chk("t4_write_off",    64'(ren_write), 64'd0);
      chk("t4_err",          64'(err),       64'd1);
      chk("t4_req_ack",      64'(req_ack),   64'b1000);
      req_write = 4'b0000;
      tick();
      chk("t4_ack_once",  64'(req_ack), 64'd0);
      chk("t4_err_stick", 64'(err),     64'd1);
      req_write = 4'b0001;
      tick();
      chk("t4_next_write", 64'(ren_write), 64'd1);
      chk("t4_next_grant", 64'(grant),     64'd0);
      ren_ack = 1'b1;
      tick();
      ren_ack = 1'b0;
      chk("t4_next_ack",  64'(req_ack), 64'b0001);
      chk("t4_err_stick2", 64'(err),    64'd1);
      req_write = 4'b0000;
      tick();

      // Reset during ISSUE drops the transaction
      req_write = 4'b0010;
      tick();
      chk("t5_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      tick();
      chk("t5_write", 64'(ren_write), 64'd0);
      chk("t5_ack",   64'(req_ack),   64'd0);
      chk("t5_busy0", 64'(busy),      64'd0);
      chk("t5_err",   64'(err),       64'd0);
      chk("t5_grant", 64'(grant),     64'd0);
      chk("t5_x",     64'(ren_x),     64'd0);
      rst_n     = 1'b1;
      req_write = 4'b1001;
      tick();
      chk("t5_tie_grant", 64'(grant),     64'd0);
      chk("t5_tie_write", 64'(ren_write), 64'd1);
      ren_ack = 1'b1;
      tick();
      ren_ack = 1'b0;
      chk("t5_tie_ack", 64'(req_ack), 64'b0001);
      req_write = 4'b0000;
      tick();

      // Ack coincident with watchdog expiry is a normal completion
      req_write = 4'b0100;
      tick();
      repeat (15) tick();
      chk("t7_write_16th", 64'(ren_write), 64'd1);
      ren_ack = 1'b1;
      tick();
      ren_ack = 1'b0;
      chk("t7_req_ack", 64'(req_ack), 64'b0100);
      chk("t7_no_err",  64'(err),     64'd0);
      req_write = 4'b0000;
      tick();
      chk("t7_idle", 64'(busy), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
